ram_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM (one access per clock, 1-cycle read latency, write-enable suppresses the read) between two requesters.
- Port 0 is the processor data-memory port. Port 1 is the display/game-logic port.
- Sits directly in front of the RAM and drives its wEn/addr/dataIn; returns read data with a valid strobe.
- Round-robin arbitration, optional bus lock, and a bounded lock length to prevent starvation.

---
 rtl/ram_arbiter_if.sv | 26 ++
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side bus for one port of the shared data RAM arbiter.
interface ram_arbiter_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 12
);
   logic                     req;
   logic                     wEn;
   logic                     lock;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0]    dataIn;
   logic                     gnt;
   logic                     rvalid;
   logic [DATA_WIDTH-1:0]    dataOut;

   // Requester drives the access, sees grant and read return.
   modport master (
      output req, wEn, lock, addr, dataIn,
      input  gnt, rvalid, dataOut
   );

   // Arbiter sees the access, drives grant and read return.
   modport slave (
      input  req, wEn, lock, addr, dataIn,
      output gnt, rvalid, dataOut
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM,
// with optional grant locking bounded by MAX_LOCK contended grants.
module ram_arbiter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned MAX_LOCK      = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   ram_arbiter_if.slave             m0,
   ram_arbiter_if.slave             m1,
   output logic                     ram_wEn,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_dataIn,
   input  logic [DATA_WIDTH-1:0]    ram_dataOut
);
   localparam int unsigned CNT_WIDTH = 8;
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LOCK);

   logic                 last;
   logic                 owner;
   logic                 locked;
   logic [CNT_WIDTH-1:0] lock_cnt;
   logic                 rv0;
   logic                 rv1;

   logic owner_req;
   logic other_req;
   logic forced;
   logic gnt0;
   logic gnt1;
   logic gnt_any;
   logic gnt_port;
   logic gnt_lock;

   // Same-cycle grant: lock holder first (unless its bound is used up), then round robin.
   always_comb begin
      owner_req = owner ? m1.req : m0.req;
      other_req = owner ? m0.req : m1.req;
      forced    = locked && owner_req && other_req && (lock_cnt == MAX_CNT);
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      if (locked && owner_req) begin
         if (forced) begin
            gnt0 = owner;
            gnt1 = !owner;
         end else begin
            gnt0 = !owner;
            gnt1 = owner;
         end
      end else if (m0.req && !m1.req) begin
         gnt0 = 1'b1;
      end else if (m1.req && !m0.req) begin
         gnt1 = 1'b1;
      end else if (m0.req && m1.req) begin
         gnt0 = last;
         gnt1 = !last;
      end
      gnt_any  = gnt0 || gnt1;
      gnt_port = gnt1;
      gnt_lock = gnt1 ? m1.lock : m0.lock;
   end

   // RAM drive mux; idle cycles issue a harmless read of address 0.
   always_comb begin
      ram_wEn    = 1'b0;
      ram_addr   = '0;
      ram_dataIn = '0;
      if (gnt1) begin
         ram_wEn    = m1.wEn;
         ram_addr   = m1.addr;
         ram_dataIn = m1.dataIn;
      end else if (gnt0) begin
         ram_wEn    = m0.wEn;
         ram_addr   = m0.addr;
         ram_dataIn = m0.dataIn;
      end
   end

   // Arbitration history, lock ownership, lock bound counter and read-valid pipe.
   always_ff @(posedge clk) begin
      if (reset) begin
         last     <= 1'b1;
         owner    <= 1'b0;
         locked   <= 1'b0;
         lock_cnt <= '0;
         rv0      <= 1'b0;
         rv1      <= 1'b0;
      end else begin
         rv0 <= gnt0 && !m0.wEn;
         rv1 <= gnt1 && !m1.wEn;
         if (gnt_any) begin
            last <= gnt_port;
         end
         if (gnt_any && gnt_lock && !forced) begin
            locked <= 1'b1;
            owner  <= gnt_port;
         end else begin
            locked <= 1'b0;
         end
         if (!forced && locked && gnt_any && (gnt_port == owner) && other_req) begin
            lock_cnt <= (lock_cnt == MAX_CNT) ? lock_cnt : lock_cnt + CNT_WIDTH'(1);
         end else begin
            lock_cnt <= '0;
         end
      end
   end

   assign m0.gnt     = gnt0;
   assign m1.gnt     = gnt1;
   assign m0.rvalid  = rv0;
   assign m1.rvalid  = rv1;
   assign m0.dataOut = ram_dataOut;
   assign m1.dataOut = ram_dataOut;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, rule-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ram_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 12;
   localparam int MAXL = 3;

   logic clk;
   logic reset;
   logic          ram_wEn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dataIn;
   logic [DW-1:0] ram_dataOut;

   int n_tests = 0;
   int n_fail  = 0;

   ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) m0 ();
   ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) m1 ();

   ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_LOCK(MAXL)) dut (
      .clk        (clk),
      .reset      (reset),
      .m0         (m0),
      .m1         (m1),
      .ram_wEn    (ram_wEn),
      .ram_addr   (ram_addr),
      .ram_dataIn (ram_dataIn),
      .ram_dataOut(ram_dataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [11:0] a);
      if (a == 12'h010) return 32'hDEADBEEF;
      return {20'hA5A5A, a};
   endfunction

   // Single-port synchronous RAM, 1-cycle read latency, write suppresses read.
   logic [31:0] ram_mem [0:4095];
   initial begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= init_word(12'(i));
   end
   always @(posedge clk) begin
      if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
      else         ram_dataOut       <= ram_mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model state: what the arbiter must have remembered.
   bit          mdl_on   = 1'b0;
   bit          m_last   = 1'b1;
   bit          m_owner  = 1'b0;
   bit          m_locked = 1'b0;
   int          m_streak = 0;
   bit          exp_rv   [2];
   logic [31:0] exp_data [2];
   logic [31:0] shadow   [int];

   function automatic logic [31:0] peek(input logic [11:0] a);
      if (shadow.exists(int'(a))) return shadow[int'(a)];
      return init_word(a);
   endfunction

   // Per-cycle comparison against the arbitration rules.
   always @(negedge clk) begin
      bit          r [2];
      bit          w [2];
      bit          l [2];
      logic [11:0] a [2];
      logic [31:0] d [2];
      bit          any;
      bit          g;
      bit          forced;
      bit          contested;
      r[0] = m0.req; w[0] = m0.wEn; l[0] = m0.lock; a[0] = m0.addr; d[0] = m0.dataIn;
      r[1] = m1.req; w[1] = m1.wEn; l[1] = m1.lock; a[1] = m1.addr; d[1] = m1.dataIn;
      forced = m_locked && r[m_owner] && r[!m_owner] && (m_streak == MAXL);
      any = 1'b1;
      g   = 1'b0;
      if (m_locked && r[m_owner]) g = forced ? !m_owner : m_owner;
      else if (r[0] && !r[1])     g = 1'b0;
      else if (r[1] && !r[0])     g = 1'b1;
      else if (r[0] && r[1])      g = !m_last;
      else                        any = 1'b0;
      if (mdl_on) begin
         check("gnt0", 32'(m0.gnt), 32'(any && !g));
         check("gnt1", 32'(m1.gnt), 32'(any && g));
         check("ram_wEn", 32'(ram_wEn), any ? 32'(w[g]) : 32'(0));
         check("ram_addr", 32'(ram_addr), any ? 32'(a[g]) : 32'(0));
         check("ram_dataIn", ram_dataIn, any ? d[g] : 32'(0));
         check("rvalid0", 32'(m0.rvalid), 32'(exp_rv[0]));
         check("rvalid1", 32'(m1.rvalid), 32'(exp_rv[1]));
         if (exp_rv[0]) check("dataOut0", m0.dataOut, exp_data[0]);
         if (exp_rv[1]) check("dataOut1", m1.dataOut, exp_data[1]);
      end
      if (reset) begin
         mdl_on    = 1'b1;
         m_last    = 1'b1;
         m_owner   = 1'b0;
         m_locked  = 1'b0;
         m_streak  = 0;
         exp_rv[0] = 1'b0;
         exp_rv[1] = 1'b0;
      end else if (mdl_on) begin
         for (int p = 0; p < 2; p++) begin
            exp_rv[p] = any && (g == 1'(p)) && !w[p];
            if (exp_rv[p]) exp_data[p] = peek(a[p]);
         end
         if (any && w[g]) shadow[int'(a[g])] = d[g];
         contested = m_locked && any && (g == m_owner) && r[!m_owner];
         if (contested && !forced) m_streak = (m_streak < MAXL) ? m_streak + 1 : MAXL;
         else                      m_streak = 0;
         if (any) m_last = g;
         if (any && l[g] && !forced) begin
            m_locked = 1'b1;
            m_owner  = g;
         end else begin
            m_locked = 1'b0;
         end
      end
   end

   task automatic set_port(input int p, input bit req, input bit wen, input bit lock,
                           input logic [11:0] addr, input logic [31:0] data);
      if (p == 0) begin
         m0.req = req; m0.wEn = wen; m0.lock = lock; m0.addr = addr; m0.dataIn = data;
      end else begin
         m1.req = req; m1.wEn = wen; m1.lock = lock; m1.addr = addr; m1.dataIn = data;
      end
   endtask

   task automatic idle();
      set_port(0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
      set_port(1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      settle();
      check("reset_rvalid0", 32'(m0.rvalid), 32'(0));
      check("reset_rvalid1", 32'(m1.rvalid), 32'(0));
      tick();

      // Single read of a preloaded word
      set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
      settle();
      check("single_gnt0", 32'(m0.gnt), 32'(1));
      check("single_gnt1", 32'(m1.gnt), 32'(0));
      tick();
      idle();
      settle();
      check("single_rvalid0", 32'(m0.rvalid), 32'(1));
      check("single_data", m0.dataOut, 32'hDEADBEEF);
      check("single_rvalid1", 32'(m1.rvalid), 32'(0));
      check("single_gnt1b", 32'(m1.gnt), 32'(0));
      tick();

      // Round robin under continuous contention
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_port(0, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
         set_port(1, 1'b1, 1'b0, 1'b0, 12'h030, 32'h0);
         settle();
         check("rr_gnt0", 32'(m0.gnt), 32'(i % 2 == 0));
         check("rr_gnt1", 32'(m1.gnt), 32'(i % 2 == 1));
         if (i > 0) begin
            check("rr_rvalid0", 32'(m0.rvalid), 32'(i % 2 == 1));
            check("rr_rvalid1", 32'(m1.rvalid), 32'(i % 2 == 0));
         end
         tick();
      end
      idle();
      settle();
      check("rr_rvalid1_last", 32'(m1.rvalid), 32'(1));
      check("rr_data1_last", m1.dataOut, 32'hA5A5A030);
      tick();

      // Write by port 1, read back by port 0 on the next cycle
      set_port(1, 1'b1, 1'b1, 1'b0, 12'h7FF, 32'h00000042);
      settle();
      check("wr_gnt1", 32'(m1.gnt), 32'(1));
      tick();
      idle();
      set_port(0, 1'b1, 1'b0, 1'b0, 12'h7FF, 32'h0);
      settle();
      check("wr_gnt0", 32'(m0.gnt), 32'(1));
      check("wr_rvalid1", 32'(m1.rvalid), 32'(0));
      tick();
      idle();
      settle();
      check("wr_rvalid0", 32'(m0.rvalid), 32'(1));
      check("wr_data0", m0.dataOut, 32'h00000042);
      check("wr_rvalid1b", 32'(m1.rvalid), 32'(0));
      tick();

      // Lock held by port 0, bounded once port 1 contends
      do_reset();
      for (int c = 0; c < 8; c++) begin
         set_port(0, 1'b1, 1'b0, 1'b1, 12'h100, 32'h0);
         set_port(1, (c >= 2 && c <= 5), 1'b0, 1'b0, 12'h200, 32'h0);
         settle();
         check("lock_gnt0", 32'(m0.gnt), 32'(c != 5));
         check("lock_gnt1", 32'(m1.gnt), 32'(c == 5));
         tick();
      end
      set_port(0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
      set_port(1, 1'b1, 1'b0, 1'b0, 12'h200, 32'h0);
      settle();
      check("unlock_gnt1", 32'(m1.gnt), 32'(1));
      check("unlock_rvalid0", 32'(m0.rvalid), 32'(1));
      tick();
      idle();
      tick();

      // Mixed reads, writes and port 1 locking on a small address window
      for (int i = 0; i < 16; i++) begin
         set_port(0, (i % 3 != 2), (i % 4 == 1), 1'b0, 12'(12'h300 + i % 2), 32'h1000 + 32'(i));
         set_port(1, (i % 5 != 0), (i % 3 == 0), (i >= 6 && i < 14),
                  12'(12'h300 + (i + 1) % 2), 32'h2000 + 32'(i));
         tick();
      end
      idle();
      tick();

      // Reset while a read is being granted
      set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
      reset = 1'b1;
      settle();
      check("rst_gnt0", 32'(m0.gnt), 32'(1));
      tick();
      reset = 1'b0;
      set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
      set_port(1, 1'b1, 1'b0, 1'b0, 12'h011, 32'h0);
      settle();
      check("rst_rvalid0", 32'(m0.rvalid), 32'(0));
      check("rst_first_gnt0", 32'(m0.gnt), 32'(1));
      check("rst_first_gnt1", 32'(m1.gnt), 32'(0));
      tick();
      idle();
      settle();
      check("rst_reissue_rvalid0", 32'(m0.rvalid), 32'(1));
      check("rst_reissue_data", m0.dataOut, 32'hDEADBEEF);
      tick();

      // Idle bus
      for (int i = 0; i < 4; i++) begin
         settle();
         check("idle_ram_wEn", 32'(ram_wEn), 32'(0));
         check("idle_ram_addr", 32'(ram_addr), 32'(0));
         check("idle_gnt0", 32'(m0.gnt), 32'(0));
         check("idle_gnt1", 32'(m1.gnt), 32'(0));
         check("idle_rvalid0", 32'(m0.rvalid), 32'(0));
         check("idle_rvalid1", 32'(m1.rvalid), 32'(0));
         tick();
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
